uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame, LSB first.
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning s_tick count in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 The block SHALL have parameter BIT_WIDTH, default 16 (even, >= 4), meaning s_tick oversampling ticks per bit.
REQ-004 Port clk  input  1  system clock; all flops on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port s_tick  input  1  one-clk pulse at BIT_WIDTH x baud rate.
REQ-007 Port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-008 Port rx_dout  output  DBIT  last received data word, registered.
REQ-009 Port rx_done  output  1  one-clk pulse: frame complete, rx_dout valid.
REQ-010 Port frame_err  output  1  one-clk pulse with rx_done: stop bit sampled low.

Function
REQ-011 The block SHALL pass rx through a 2-flop synchronizer (reset value 1); rx_s (second-stage flop) SHALL be the only rx value used by the FSM.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP; illegal encodings SHALL go to IDLE.
REQ-013 In IDLE, rx_s = 0 SHALL move to START with s_cnt <= 0; rx_s = 1 SHALL hold IDLE.
REQ-014 START: on each s_tick, s_cnt increments; at s_tick with s_cnt == BIT_WIDTH/2-1, rx_s = 0 SHALL move to DATA with s_cnt <= 0 and n_cnt <= 0; rx_s = 1 SHALL return to IDLE (false start, no output pulse).
REQ-015 DATA: on each s_tick, s_cnt increments; at s_tick with s_cnt == BIT_WIDTH-1, the block SHALL set s_cnt <= 0 and shift b_reg <= {rx_s, b_reg[DBIT-1:1]}; if n_cnt == DBIT-1, it SHALL set n_cnt <= 0 and move to STOP; otherwise n_cnt increments.
REQ-016 STOP: on each s_tick, s_cnt increments; at s_tick with s_cnt == SB_TICK-1, the block SHALL sample rx_s, set s_cnt <= 0 and go to IDLE.
REQ-017 The cycle after the REQ-016 event, rx_done SHALL be 1 for exactly one clk, and rx_dout SHALL equal the shifted b_reg; frame_err SHALL be 1 in the same cycle only if the stop sample was 0.
REQ-018 On a framing error, rx_dout SHALL still update.
REQ-019 rx_dout SHALL hold its value between frames and change only in the rx_done cycle.
REQ-020 Without s_tick, s_cnt, n_cnt and b_reg SHALL hold, and the state SHALL not change except IDLE->START.
REQ-021 s_cnt width SHALL be $clog2(max(BIT_WIDTH, SB_TICK)); n_cnt width SHALL be $clog2(DBIT); no counter SHALL wrap except by the explicit clears above.
REQ-022 A falling rx_s in the same cycle that STOP exits SHALL be seen by IDLE on the next clk (back-to-back frames, no lost frame).

Reset
REQ-023 rst_n = 0 SHALL at once force state IDLE, s_cnt = 0, n_cnt = 0, b_reg = 0, rx_dout = 0, rx_done = 0, frame_err = 0, and both synchronizer flops to 1.
REQ-024 Reset during any state SHALL abort the frame with no rx_done pulse; after release, a new frame SHALL receive correctly.

Verification
REQ-025 Reset: assert rst_n low at a random clk phase -> all outputs 0 immediately and held while low.
REQ-026 Frame 0xA5 with defaults, s_tick every 4 clk, 1 stop bit -> one rx_done pulse, rx_dout = 0xA5, frame_err = 0, rx_done high exactly 1 clk.
REQ-027 rx low for 5 s_ticks then high (glitch) -> back to IDLE, no rx_done, rx_dout unchanged.
REQ-028 Frame 0x3C with stop bit driven 0 -> rx_done = 1 and frame_err = 1 in the same cycle, rx_dout = 0x3C.
REQ-029 rst_n pulsed low in DATA after 3 bits, then frame 0x81 -> no pulse for the aborted frame; rx_dout = 0x81 after the second frame.
REQ-030 Frames 0x00, 0xFF, 0x55 sent back-to-back, no idle between them, SB_TICK = 16 -> three rx_done pulses in order with matching rx_dout; repeat with SB_TICK = 32.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing of a serial line into a DBIT word.
// Latency: rx_done/rx_dout/frame_err register one clk after the stop-bit sample point.
// Backpressure: none; each word is presented for one clk and rx_dout holds until the next frame.
module uart_rx #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int BIT_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done,
  output logic            frame_err
);

  // The tick counter must reach the larger of one bit time and the stop period.
  localparam int CMAX = (BIT_WIDTH > SB_TICK) ? BIT_WIDTH : SB_TICK;
  localparam int SW   = $clog2(CMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_ONE     = SW'(1);
  localparam logic [SW-1:0] HALF_LAST = SW'(BIT_WIDTH / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(BIT_WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_ONE     = NW'(1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_reg_q, b_reg_d;
  logic [DBIT-1:0] rx_dout_q, rx_dout_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_meta_q, rx_s_q;
  logic [DBIT-1:0] shift_val;

  // Data arrives LSB first, so each new sample enters at the MSB and moves right.
  if (DBIT > 1) begin : g_shift_multi
    assign shift_val = {rx_s_q, b_reg_q[DBIT-1:1]};
  end else begin : g_shift_single
    assign shift_val = rx_s_q;
  end

  // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      b_reg_q     <= '0;
      rx_dout_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      b_reg_q     <= b_reg_d;
      rx_dout_q   <= rx_dout_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: only IDLE reacts without a tick; everything else advances on s_tick.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    b_reg_d     = b_reg_q;
    rx_dout_d   = rx_dout_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == HALF_LAST) begin
            // Mid start bit: still low means a real frame, high means a glitch.
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            b_reg_d = shift_val;
            if (n_cnt_q == N_LAST) begin
              n_cnt_d = '0;
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + N_ONE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            // Word is published even on a bad stop bit; frame_err flags it.
            s_cnt_d     = '0;
            state_d     = IDLE;
            rx_dout_d   = b_reg_q;
            rx_done_d   = 1'b1;
            frame_err_d = ~rx_s_q;
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_dout   = rx_dout_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames into a 1-stop-bit and a 2-stop-bit receiver.
// A frame-level scoreboard predicts each rx_done pulse with its word and error flag.
// Outputs are sampled on the falling clock edge.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       s_tick;
  logic       line;
  logic       sel;
  logic       rx_a, rx_b;
  logic [7:0] rx_dout_a, rx_dout_b;
  logic       rx_done_a, rx_done_b;
  logic       frame_err_a, frame_err_b;

  int checks;
  int errors;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] last_dout[2];
  int         done_cnt[2];
  logic       err_at_done[2];

  // Only the selected receiver sees the driven line; the other sits on an idle line.
  assign rx_a = (sel == 1'b0) ? line : 1'b1;
  assign rx_b = (sel == 1'b1) ? line : 1'b1;

  uart_rx #(.DBIT(8), .SB_TICK(16), .BIT_WIDTH(16)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tick    (s_tick),
    .rx        (rx_a),
    .rx_dout   (rx_dout_a),
    .rx_done   (rx_done_a),
    .frame_err (frame_err_a)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32), .BIT_WIDTH(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tick    (s_tick),
    .rx        (rx_b),
    .rx_dout   (rx_dout_b),
    .rx_done   (rx_done_b),
    .frame_err (frame_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick: one clk high out of every four, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of one receiver against the frame scoreboard.
  task automatic check_one(input int i, input logic done, input logic err, input logic [7:0] dout);
    exp_t e;
    if (!rst_n) begin
      chk($sformatf("dut%0d_rst_done", i), 32'(done), 32'd0);
      chk($sformatf("dut%0d_rst_err", i), 32'(err), 32'd0);
      chk($sformatf("dut%0d_rst_dout", i), 32'(dout), 32'd0);
    end else if (done) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_rx_done: got 1 expected 0 (dout %0h)", i, dout);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d_done_dout", i), 32'(dout), 32'(e.d));
        chk($sformatf("dut%0d_done_err", i), 32'(err), 32'(e.e));
        last_dout[i]   = e.d;
        err_at_done[i] = err;
        done_cnt[i]++;
      end
    end else begin
      chk($sformatf("dut%0d_idle_err", i), 32'(err), 32'd0);
      chk($sformatf("dut%0d_hold_dout", i), 32'(dout), 32'(last_dout[i]));
    end
  endtask

  always @(negedge clk) begin
    check_one(0, rx_done_a, frame_err_a, rx_dout_a);
    check_one(1, rx_done_b, frame_err_b, rx_dout_b);
  end

  // Wait for n ticks, then step just past the clock edge that consumed the last one.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (!s_tick);
    end
    #1;
  endtask

  // Full frame: start, 8 data bits LSB first, stop period of sb ticks, then idle.
  // A bad stop bit is held low past its sample point and released early enough that
  // the receiver's resulting false start is rejected before the next frame.
  task automatic send_frame(input logic tgt, input logic [7:0] d, input logic stop_ok,
                            input int sb, input int idle);
    exp_t e;
    sel = tgt;
    e.d = d;
    e.e = ~stop_ok;
    if (tgt == 1'b0) q0.push_back(e);
    else q1.push_back(e);
    line = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 8; b++) begin
      line = d[b];
      wait_ticks(16);
    end
    if (stop_ok) begin
      line = 1'b1;
      wait_ticks(sb);
    end else begin
      line = 1'b0;
      wait_ticks(sb / 2 + 4);
      line = 1'b1;
      wait_ticks(sb - sb / 2 - 4);
    end
    line = 1'b1;
    wait_ticks(idle);
  endtask

  // Asynchronous reset at a random phase that avoids both clock edges.
  task automatic do_reset(input int hold);
    int d;
    d = $urandom_range(1, 7);
    if (d >= 4) d++;
    #(d);
    rst_n = 1'b0;
    #1;
    chk("async_rst_done_a", 32'(rx_done_a), 32'd0);
    chk("async_rst_err_a", 32'(frame_err_a), 32'd0);
    chk("async_rst_dout_a", 32'(rx_dout_a), 32'd0);
    chk("async_rst_dout_b", 32'(rx_dout_b), 32'd0);
    q0.delete();
    q1.delete();
    last_dout[0] = 8'h00;
    last_dout[1] = 8'h00;
    repeat (hold) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] partial;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    line           = 1'b1;
    sel            = 1'b0;
    last_dout[0]   = 8'h00;
    last_dout[1]   = 8'h00;
    done_cnt[0]    = 0;
    done_cnt[1]    = 0;
    err_at_done[0] = 1'b0;
    err_at_done[1] = 1'b0;

    #1;
    chk("init_dout_a", 32'(rx_dout_a), 32'd0);
    chk("init_done_a", 32'(rx_done_a), 32'd0);
    chk("init_err_b", 32'(frame_err_b), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    wait_ticks(20);

    // Clean frame.
    send_frame(1'b0, 8'hA5, 1'b1, 16, 32);
    chk("a5_dout", 32'(rx_dout_a), 32'h0000_00A5);
    chk("a5_count", 32'(done_cnt[0]), 32'd1);
    chk("a5_err", 32'(err_at_done[0]), 32'd0);

    // Start-bit glitch: five ticks low is rejected at the mid-start check.
    line = 1'b0;
    wait_ticks(5);
    line = 1'b1;
    wait_ticks(32);
    chk("glitch_count", 32'(done_cnt[0]), 32'd1);
    chk("glitch_dout", 32'(rx_dout_a), 32'h0000_00A5);

    // Framing error: word still delivered, error flagged with rx_done.
    send_frame(1'b0, 8'h3C, 1'b0, 16, 32);
    chk("3c_dout", 32'(rx_dout_a), 32'h0000_003C);
    chk("3c_err", 32'(err_at_done[0]), 32'd1);
    chk("3c_count", 32'(done_cnt[0]), 32'd2);

    // Reset after three data bits, then a fresh frame.
    partial = 8'hC3;
    sel = 1'b0;
    line = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 3; b++) begin
      line = partial[b];
      wait_ticks(16);
    end
    line = 1'b1;
    do_reset(3);
    wait_ticks(20);
    chk("abort_count", 32'(done_cnt[0]), 32'd2);
    chk("abort_dout", 32'(rx_dout_a), 32'd0);
    send_frame(1'b0, 8'h81, 1'b1, 16, 32);
    chk("81_dout", 32'(rx_dout_a), 32'h0000_0081);
    chk("81_count", 32'(done_cnt[0]), 32'd3);

    // Back-to-back frames, one stop bit.
    send_frame(1'b0, 8'h00, 1'b1, 16, 0);
    send_frame(1'b0, 8'hFF, 1'b1, 16, 0);
    send_frame(1'b0, 8'h55, 1'b1, 16, 32);
    chk("b2b16_count", 32'(done_cnt[0]), 32'd6);
    chk("b2b16_dout", 32'(rx_dout_a), 32'h0000_0055);

    // Back-to-back frames, two stop bits.
    send_frame(1'b1, 8'h00, 1'b1, 32, 0);
    send_frame(1'b1, 8'hFF, 1'b1, 32, 0);
    send_frame(1'b1, 8'h55, 1'b1, 32, 32);
    chk("b2b32_count", 32'(done_cnt[1]), 32'd3);
    chk("b2b32_dout", 32'(rx_dout_b), 32'h0000_0055);
    chk("b2b32_err", 32'(err_at_done[1]), 32'd0);

    chk("pending_a", 32'(q0.size()), 32'd0);
    chk("pending_b", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
